// File: rtl/load_store_unit_if.sv
// Memory-side request/response bundle between the load/store unit and its data memory port.
// Latency: none, wires only.
// Backpressure: Mem_Gnt accepts a held request; Mem_RValid returns read data later.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  Mem_Req;
    logic                  Mem_Gnt;
    logic                  Mem_We;
    logic [ADDR_WIDTH-1:0] Mem_Addr;
    logic [3:0]            Mem_ByteEn;
    logic [31:0]           Mem_WData;
    logic                  Mem_RValid;
    logic [31:0]           Mem_RData;

    // The load/store unit drives requests and receives grant and read data.
    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData,
        input  Mem_Gnt, Mem_RValid, Mem_RData
    );

    // The memory port accepts requests and returns grant and read data.
    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData,
        output Mem_Gnt, Mem_RValid, Mem_RData
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one access per transaction, byte lanes, sign-extended loads, timeout.
// Latency: store done 2 cycles after accept, load 3, plus memory grant/read-data wait.
// Backpressure: stalls the pipeline until MEM_Done; optional LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 15
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                EX_MEM_Valid,
    input  logic                EX_MEM_MemRead,
    input  logic                EX_MEM_MemWrite,
    input  logic                EX_MEM_HalfControl,
    input  logic                EX_MEM_ByteControl,
    input  logic [31:0]         EX_MEM_Address,
    input  logic [31:0]         EX_MEM_WriteData,
    output logic                LSU_Ready,
    output logic                MEM_Stall,
    output logic                MEM_Done,
    output logic [31:0]         MEM_ReadData,
    output logic                MEM_BusError,
    output logic                MEM_Misaligned,
    load_store_unit_if.master   memBus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    state_t                state;
    logic [CNT_W-1:0]      waitCnt;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [3:0]            byteEnReg;
    logic [31:0]           wDataReg;
    logic                  weReg;
    logic                  halfReg;
    logic                  byteReg;
    logic [1:0]            laneReg;
    logic [31:0]           readDataReg;
    logic                  busErrorReg;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misalignedReg;
`endif

    logic        access;
    logic        trap;
    logic        reqActive;
    logic [3:0]  byteEnNext;
    logic [31:0] wDataNext;
    logic        unusedAddrBits;

    assign access = EX_MEM_Valid && (EX_MEM_MemRead || EX_MEM_MemWrite);
    assign unusedAddrBits = ^EX_MEM_Address[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
    // Half on an odd byte, or word off a word boundary, never reaches memory.
    assign trap = (EX_MEM_HalfControl && EX_MEM_Address[0]) ||
                  (!EX_MEM_HalfControl && !EX_MEM_ByteControl && (EX_MEM_Address[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Lane enables and lane-replicated store data for the incoming request; loads carry no write data.
    always_comb begin
        byteEnNext = 4'b1111;
        wDataNext  = EX_MEM_WriteData;
        if (EX_MEM_HalfControl) begin
            byteEnNext = EX_MEM_Address[1] ? 4'b1100 : 4'b0011;
            wDataNext  = {2{EX_MEM_WriteData[15:0]}};
        end else if (EX_MEM_ByteControl) begin
            byteEnNext = 4'b0001 << EX_MEM_Address[1:0];
            wDataNext  = {4{EX_MEM_WriteData[7:0]}};
        end
        if (!EX_MEM_MemWrite) begin
            wDataNext = '0;
        end
    end

    // Pick the addressed lane(s) of the returned word and sign-extend.
    function automatic logic [31:0] extractLoad(input logic [31:0] rData, input logic isHalf,
                                                input logic isByte, input logic [1:0] lane);
        logic [15:0] halfVal;
        logic [7:0]  byteVal;
        halfVal = lane[1] ? rData[31:16] : rData[15:0];
        case (lane)
            2'd0:    byteVal = rData[7:0];
            2'd1:    byteVal = rData[15:8];
            2'd2:    byteVal = rData[23:16];
            default: byteVal = rData[31:24];
        endcase
        if (isHalf) begin
            return {{16{halfVal[15]}}, halfVal};
        end else if (isByte) begin
            return {{24{byteVal[7]}}, byteVal};
        end
        return rData;
    endfunction

    // Transaction FSM: capture at accept, request until grant, wait for read data, report once.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            waitCnt     <= '0;
            addrReg     <= '0;
            byteEnReg   <= '0;
            wDataReg    <= '0;
            weReg       <= 1'b0;
            halfReg     <= 1'b0;
            byteReg     <= 1'b0;
            laneReg     <= '0;
            readDataReg <= '0;
            busErrorReg <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalignedReg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        addrReg     <= EX_MEM_Address[ADDR_WIDTH+1:2];
                        byteEnReg   <= byteEnNext;
                        wDataReg    <= wDataNext;
                        weReg       <= EX_MEM_MemWrite;
                        halfReg     <= EX_MEM_HalfControl;
                        byteReg     <= EX_MEM_ByteControl && !EX_MEM_HalfControl;
                        laneReg     <= EX_MEM_Address[1:0];
                        readDataReg <= '0;
                        busErrorReg <= 1'b0;
                        waitCnt     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalignedReg <= trap;
`endif
                        state       <= trap ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (memBus.Mem_Gnt) begin
                        waitCnt <= '0;
                        state   <= weReg ? DONE : WAIT_R;
                    end else if (waitCnt == LAST_WAIT) begin
                        busErrorReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (memBus.Mem_RValid) begin
                        readDataReg <= extractLoad(memBus.Mem_RData, halfReg, byteReg, laneReg);
                        state       <= DONE;
                    end else if (waitCnt == LAST_WAIT) begin
                        busErrorReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign reqActive = (state == REQ);

    assign memBus.Mem_Req    = reqActive;
    assign memBus.Mem_We     = reqActive && weReg;
    assign memBus.Mem_Addr   = reqActive ? addrReg : '0;
    assign memBus.Mem_ByteEn = reqActive ? byteEnReg : 4'b0000;
    assign memBus.Mem_WData  = reqActive ? wDataReg : 32'h0;

    assign LSU_Ready    = (state == IDLE);
    assign MEM_Stall    = ((state == IDLE) && access) || (state == REQ) || (state == WAIT_R);
    assign MEM_Done     = (state == DONE);
    assign MEM_ReadData = MEM_Done ? readDataReg : 32'h0;
    assign MEM_BusError = MEM_Done && busErrorReg;
`ifdef LSU_MISALIGN_TRAP_EN
    assign MEM_Misaligned = MEM_Done && misalignedReg;
`else
    assign MEM_Misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus hand sequences for reset, back-to-back and ignored handshakes.
// Latency: expected completion cycle per vector is written in the table.
// Backpressure: memory grant/read-data delays come from each vector; results checked via a queue.
module tb_load_store_unit;
    localparam int ADDR_WIDTH = 10;
    localparam int MAX_WAIT   = 15;
    localparam int NEVER      = 99;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        EX_MEM_Valid, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl;
    logic [31:0] EX_MEM_Address, EX_MEM_WriteData;
    logic        LSU_Ready, MEM_Stall, MEM_Done, MEM_BusError, MEM_Misaligned;
    logic [31:0] MEM_ReadData;

    always #5 Clk = ~Clk;

    load_store_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) memIf ();

    load_store_unit #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk(Clk), .Rst(Rst),
        .EX_MEM_Valid(EX_MEM_Valid), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_HalfControl(EX_MEM_HalfControl), .EX_MEM_ByteControl(EX_MEM_ByteControl),
        .EX_MEM_Address(EX_MEM_Address), .EX_MEM_WriteData(EX_MEM_WriteData),
        .LSU_Ready(LSU_Ready), .MEM_Stall(MEM_Stall), .MEM_Done(MEM_Done), .MEM_ReadData(MEM_ReadData),
        .MEM_BusError(MEM_BusError), .MEM_Misaligned(MEM_Misaligned),
        .memBus(memIf.master)
    );

    typedef struct {
        string                 name;
        bit                    rd, wr, half, byt;
        logic [31:0]           addr, wdata;
        int                    gntDelay, rvDelay;
        logic [31:0]           rdata;
        logic [ADDR_WIDTH-1:0] expAddr;
        logic [3:0]            expBe;
        logic [31:0]           expWData;
        logic                  expWe;
        logic [31:0]           expRead;
        logic                  expErr, expMis;
        int                    expDone, expReqCycles;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err, mis;
    } res_t;

    vec_t vecs[$];
    res_t sbQ[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input bit rd, wr, half, byt, input logic [31:0] addr, wdata,
                          input int gnt, rv, input logic [31:0] rdata, input logic [ADDR_WIDTH-1:0] eAddr,
                          input logic [3:0] eBe, input logic [31:0] eWData, input logic eWe,
                          input logic [31:0] eRead, input logic eErr, eMis, input int eDone, eReq);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.half = half; v.byt = byt; v.addr = addr; v.wdata = wdata;
        v.gntDelay = gnt; v.rvDelay = rv; v.rdata = rdata; v.expAddr = eAddr; v.expBe = eBe;
        v.expWData = eWData; v.expWe = eWe; v.expRead = eRead; v.expErr = eErr; v.expMis = eMis;
        v.expDone = eDone; v.expReqCycles = eReq;
        vecs.push_back(v);
    endtask

    task automatic clearInputs();
        EX_MEM_Valid = 0; EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0;
        EX_MEM_HalfControl = 0; EX_MEM_ByteControl = 0;
        EX_MEM_Address = 0; EX_MEM_WriteData = 0;
    endtask

    function automatic bit busNonZero();
        return (memIf.Mem_Addr != 0) || (memIf.Mem_ByteEn != 0) || (memIf.Mem_WData != 0) || memIf.Mem_We;
    endfunction

    // Completion monitor: every MEM_Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        res_t e;
        if (MEM_Done) begin
            if (sbQ.size() == 0) begin
                check("unexpected_done", {63'd0, MEM_Done}, 64'd0);
            end else begin
                e = sbQ.pop_front();
                check({e.name, "_rdata"}, {32'd0, MEM_ReadData}, {32'd0, e.rd});
                check({e.name, "_buserr"}, {63'd0, MEM_BusError}, {63'd0, e.err});
                check({e.name, "_misalign"}, {63'd0, MEM_Misaligned}, {63'd0, e.mis});
            end
        end
    end

    // Drives one vector from its accept cycle (c0) and plays the memory port with the vector's delays.
    task automatic runVec(input vec_t v);
        int cyc, reqCycles, waitCycles, doneCyc;
        bit reqBad, busIdleBad, stallBad;
        res_t r;
        EX_MEM_Valid = 1; EX_MEM_MemRead = v.rd; EX_MEM_MemWrite = v.wr;
        EX_MEM_HalfControl = v.half; EX_MEM_ByteControl = v.byt;
        EX_MEM_Address = v.addr; EX_MEM_WriteData = v.wdata;
        #1;
        check({v.name, "_ready_c0"}, {63'd0, LSU_Ready}, 64'd1);
        check({v.name, "_stall_c0"}, {63'd0, MEM_Stall}, 64'd1);
        r.name = v.name; r.rd = v.expRead; r.err = v.expErr; r.mis = v.expMis;
        sbQ.push_back(r);
        @(negedge Clk);
        clearInputs();
        cyc = 1; reqCycles = 0; waitCycles = 0; doneCyc = -1;
        reqBad = 0; busIdleBad = 0; stallBad = 0;
        while (doneCyc < 0 && cyc < 40) begin
            if (MEM_Done) begin
                doneCyc = cyc;
                if (MEM_Stall || LSU_Ready) stallBad = 1;
                if (memIf.Mem_Req || busNonZero()) busIdleBad = 1;
            end else begin
                if (!MEM_Stall || LSU_Ready) stallBad = 1;
                if (memIf.Mem_Req) begin
                    if (memIf.Mem_Addr !== v.expAddr || memIf.Mem_ByteEn !== v.expBe ||
                        memIf.Mem_WData !== v.expWData || memIf.Mem_We !== v.expWe) reqBad = 1;
                    if (reqCycles == v.gntDelay) memIf.Mem_Gnt = 1;
                    reqCycles++;
                end else begin
                    if (busNonZero()) busIdleBad = 1;
                    if (waitCycles == v.rvDelay) begin
                        memIf.Mem_RValid = 1;
                        memIf.Mem_RData  = v.rdata;
                    end
                    waitCycles++;
                end
            end
            @(negedge Clk);
            memIf.Mem_Gnt = 0; memIf.Mem_RValid = 0; memIf.Mem_RData = 32'h5A5A_5A5A;
            cyc++;
        end
        check({v.name, "_done_cycle"}, 64'(doneCyc), 64'(v.expDone));
        check({v.name, "_req_cycles"}, 64'(reqCycles), 64'(v.expReqCycles));
        check({v.name, "_req_fields"}, {63'd0, reqBad}, 64'd0);
        check({v.name, "_bus_zero"}, {63'd0, busIdleBad}, 64'd0);
        check({v.name, "_stall_ready"}, {63'd0, stallBad}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ignoredBad;
        //      name          rd wr hf by addr          wdata        gnt rv     rdata         eAddr    eBe      eWData        eWe eRead         err mis done req
        addVec("st_byte",     0, 1, 0, 1, 32'h0000_0013, 32'h0000_00A5, 0, NEVER, 32'h0,        10'h004, 4'b1000, 32'hA5A5_A5A5, 1, 32'h0,        0, 0, 2,  1);
        addVec("ld_half",     1, 0, 1, 0, 32'h0000_0006, 32'h0,         1, 1,     32'h8001_1234, 10'h001, 4'b1100, 32'h0,        0, 32'hFFFF_8001, 0, 0, 5,  2);
        addVec("ld_byte1",    1, 0, 0, 1, 32'h0000_0001, 32'h0,         0, 0,     32'h0000_7F00, 10'h000, 4'b0010, 32'h0,        0, 32'h0000_007F, 0, 0, 3,  1);
        addVec("ld_word",     1, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0,     32'h0000_7F00, 10'h000, 4'b1111, 32'h0,        0, 32'h0000_7F00, 0, 0, 3,  1);
        addVec("ld_byte3",    1, 0, 0, 1, 32'h0000_0003, 32'h0,         0, 2,     32'h8012_3456, 10'h000, 4'b1000, 32'h0,        0, 32'hFFFF_FF80, 0, 0, 5,  1);
        addVec("st_half_hi",  0, 1, 1, 0, 32'h0000_0102, 32'h1234_BEEF, 3, NEVER, 32'h0,        10'h040, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0,        0, 0, 5,  4);
        addVec("st_word_top", 0, 1, 0, 0, 32'h0000_0FFC, 32'hDEAD_BEEF, 0, NEVER, 32'h0,        10'h3FF, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0,        0, 0, 2,  1);
        addVec("rdwr_store",  1, 1, 0, 1, 32'h0000_0000, 32'hFFFF_FF3C, 0, NEVER, 32'h0,        10'h000, 4'b0001, 32'h3C3C_3C3C, 1, 32'h0,        0, 0, 2,  1);
        addVec("half_wins",   1, 0, 1, 1, 32'h0000_0004, 32'h0,         0, 0,     32'hABCD_8000, 10'h001, 4'b0011, 32'h0,        0, 32'hFFFF_8000, 0, 0, 3,  1);
        addVec("ld_half_hi",  1, 0, 1, 0, 32'h0000_0002, 32'h0,         0, 0,     32'h7FFF_0080, 10'h000, 4'b1100, 32'h0,        0, 32'h0000_7FFF, 0, 0, 3,  1);
        addVec("gnt_timeout", 0, 1, 0, 0, 32'h0000_0008, 32'h0123_4567, NEVER, NEVER, 32'h0,    10'h002, 4'b1111, 32'h0123_4567, 1, 32'h0,        1, 0, 16, 15);
        addVec("rv_timeout",  1, 0, 0, 0, 32'h0000_0010, 32'h0,         2, NEVER, 32'h1111_2222, 10'h004, 4'b1111, 32'h0,        0, 32'h0,        1, 0, 19, 3);
`ifdef LSU_MISALIGN_TRAP_EN
        addVec("mis_word",    1, 0, 0, 0, 32'h0000_0002, 32'h0,         0, 0,     32'hCAFE_F00D, 10'h000, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 1,  0);
        addVec("mis_half_ld", 1, 0, 1, 0, 32'h0000_0005, 32'h0,         0, 0,     32'h0000_8080, 10'h000, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 1,  0);
        addVec("mis_half_st", 0, 1, 1, 0, 32'h0000_0007, 32'h0000_ABCD, 0, NEVER, 32'h0,        10'h000, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 1,  0);
`else
        addVec("mis_word",    1, 0, 0, 0, 32'h0000_0002, 32'h0,         0, 0,     32'hCAFE_F00D, 10'h000, 4'b1111, 32'h0,        0, 32'hCAFE_F00D, 0, 0, 3,  1);
        addVec("mis_half_ld", 1, 0, 1, 0, 32'h0000_0005, 32'h0,         0, 0,     32'h0000_8080, 10'h001, 4'b0011, 32'h0,        0, 32'hFFFF_8080, 0, 0, 3,  1);
        addVec("mis_half_st", 0, 1, 1, 0, 32'h0000_0007, 32'h0000_ABCD, 0, NEVER, 32'h0,        10'h001, 4'b1100, 32'hABCD_ABCD, 1, 32'h0,        0, 0, 2,  1);
`endif

        Rst = 1; clearInputs();
        memIf.Mem_Gnt = 0; memIf.Mem_RValid = 0; memIf.Mem_RData = 0;
        repeat (3) @(negedge Clk);
        Rst = 0;
        @(negedge Clk);
        check("reset_ready", {63'd0, LSU_Ready}, 64'd1);
        check("reset_flags", {60'd0, MEM_Stall, MEM_Done, MEM_BusError, MEM_Misaligned}, 64'd0);
        check("reset_rdata", {32'd0, MEM_ReadData}, 64'd0);
        check("reset_bus", {63'd0, memIf.Mem_Req | busNonZero()}, 64'd0);

        foreach (vecs[i]) runVec(vecs[i]);

        // Grant and read data while idle must be ignored.
        ignoredBad = 0;
        repeat (3) begin
            memIf.Mem_Gnt = 1; memIf.Mem_RValid = 1; memIf.Mem_RData = 32'hFFFF_FFFF;
            @(negedge Clk);
            if (!LSU_Ready || memIf.Mem_Req || MEM_Done || MEM_Stall) ignoredBad = 1;
        end
        memIf.Mem_Gnt = 0; memIf.Mem_RValid = 0;
        check("idle_ignores_handshake", {63'd0, ignoredBad}, 64'd0);

        // Reset while waiting for read data; a late RValid must not complete anything.
        EX_MEM_Valid = 1; EX_MEM_MemRead = 1; EX_MEM_Address = 32'h20;
        @(negedge Clk);
        clearInputs();
        check("rst_mid_req", {63'd0, memIf.Mem_Req}, 64'd1);
        memIf.Mem_Gnt = 1;
        @(negedge Clk);
        memIf.Mem_Gnt = 0;
        check("rst_mid_waitr", {62'd0, memIf.Mem_Req, MEM_Stall}, 64'b01);
        Rst = 1;
        @(negedge Clk);
        Rst = 0;
        check("rst_mid_idle", {61'd0, LSU_Ready, memIf.Mem_Req, MEM_Done}, 64'b100);
        memIf.Mem_RValid = 1; memIf.Mem_RData = 32'h1234_5678;
        @(negedge Clk);
        memIf.Mem_RValid = 0;
        check("rst_mid_late_rvalid", {61'd0, LSU_Ready, memIf.Mem_Req, MEM_Done}, 64'b100);
        @(negedge Clk);
        check("rst_mid_no_done", {63'd0, MEM_Done}, 64'd0);

        // Valid held through DONE: no accept in DONE, next accept the cycle after.
        EX_MEM_Valid = 1; EX_MEM_MemWrite = 1; EX_MEM_Address = 32'h30; EX_MEM_WriteData = 32'h1111_2222;
        sbQ.push_back('{name: "b2b_first", rd: 32'h0, err: 1'b0, mis: 1'b0});
        @(negedge Clk);
        memIf.Mem_Gnt = 1;
        @(negedge Clk);
        memIf.Mem_Gnt = 0;
        check("b2b_done_state", {61'd0, MEM_Done, LSU_Ready, MEM_Stall}, 64'b100);
        @(negedge Clk);
        check("b2b_reaccept", {61'd0, LSU_Ready, MEM_Stall, memIf.Mem_Req}, 64'b110);
        sbQ.push_back('{name: "b2b_second", rd: 32'h0, err: 1'b0, mis: 1'b0});
        @(negedge Clk);
        clearInputs();
        check("b2b_second_req", {32'd0, memIf.Mem_WData}, 64'h1111_2222);
        memIf.Mem_Gnt = 1;
        @(negedge Clk);
        memIf.Mem_Gnt = 0;
        check("b2b_second_done", {63'd0, MEM_Done}, 64'd1);
        @(negedge Clk);

        check("scoreboard_drained", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit for the MEM stage. Takes one load/store per transaction from the EX/MEM pipeline register, converts it to a word-addressed memory request with byte enables and lane-replicated write data, runs a req/gnt/rvalid handshake to a multi-cycle data memory port, and returns the sign-extended load result. Stalls the pipeline until the access completes, and bounds every access with a timeout.

## Interface
- ADDR_WIDTH, 10, word-address bits driven on Mem_Addr
- MAX_WAIT, 15, cycles allowed in REQ or WAIT_R before bus error (≥1)

- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous, active-high reset
- EX_MEM_Valid  in  1  request present
- EX_MEM_MemRead  in  1  load
- EX_MEM_MemWrite  in  1  store (wins if both set)
- EX_MEM_HalfControl  in  1  halfword access (wins over byte)
- EX_MEM_ByteControl  in  1  byte access
- EX_MEM_Address  in  32  byte address
- EX_MEM_WriteData  in  32  store data, low bits used for half/byte
- LSU_Ready  out  1  high only in IDLE
- MEM_Stall  out  1  pipeline hold
- MEM_Done  out  1  one-cycle completion pulse
- MEM_ReadData  out  32  load result, valid with MEM_Done
- MEM_BusError  out  1  timeout, valid with MEM_Done
- MEM_Misaligned  out  1  misalignment trap, valid with MEM_Done
- Mem_Req  out  1  memory request
- Mem_Gnt  in  1  request accepted
- Mem_We  out  1  write request
- Mem_Addr  out  ADDR_WIDTH  EX_MEM_Address[ADDR_WIDTH+1:2]
- Mem_ByteEn  out  4  lane enables
- Mem_WData  out  32  lane-replicated store data
- Mem_RValid  in  1  read data valid
- Mem_RData  in  32  read data

## Operation
- Access = EX_MEM_Valid && (MemRead || MemWrite). Accepted when Access && LSU_Ready; all request fields registered at accept.
- States: IDLE, REQ, WAIT_R, DONE.
  - IDLE: Access → REQ (or DONE if trapped misaligned).
  - REQ: Mem_Req=1; Gnt && write → DONE; Gnt && read → WAIT_R; timeout → DONE with error.
  - WAIT_R: Mem_RValid → capture Mem_RData, → DONE; timeout → DONE with error.
  - DONE: MEM_Done=1, → IDLE.
- Mem_Addr/Mem_We/Mem_ByteEn/Mem_WData held stable while Mem_Req=1; all zero when Mem_Req=0.
- Byte enables (little-endian lanes): word 4'b1111; half addr[1]?4'b1100:4'b0011; byte 4'b0001<<addr[1:0].
- Mem_WData: word as is; half {2{wd[15:0]}}; byte {4{wd[7:0]}}.
- Load extraction: half = addr[1] ? rdata[31:16] : rdata[15:0], sign-extended; byte = lane addr[1:0], sign-extended; word unmodified.
- MEM_Stall = (IDLE && Access) || state ∈ {REQ, WAIT_R}; low in DONE.
- Timeout counter: cleared on entering REQ and on Gnt; increments each cycle in REQ/WAIT_R; at MAX_WAIT → DONE, MEM_BusError=1, MEM_ReadData=0.
- Mem_RValid outside WAIT_R ignored; Mem_Gnt outside REQ ignored.
- Stores: MEM_ReadData=0 in DONE.

## Timing
- Reset values: state IDLE, all outputs 0 except LSU_Ready=1; counter 0.
- Rst mid-transaction: next cycle IDLE, Mem_Req=0, no MEM_Done; late RValid ignored.
- Minimum store: accept c0, Req+Gnt c1, MEM_Done c2.
- Minimum load: accept c0, Req+Gnt c1, RValid c2 (earliest after Gnt), MEM_Done c3.
- Trapped misaligned: accept c0, MEM_Done c1, Mem_Req never asserted.
- No new accept in DONE; next request accepted earliest cycle after MEM_Done.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 skips memory, completes via DONE with MEM_Misaligned=1, MEM_ReadData=0, no store performed.
- Undefined: misalignment ignored — word uses addr[1:0]=0, half ignores addr[0]; MEM_Misaligned tied 0.

## Test plan
- Store byte 0xA5 to 0x0000_0013, Gnt c1 → Mem_Addr=4, Mem_ByteEn=4'b1000, Mem_WData=0xA5A5A5A5, MEM_Done c2, MEM_Stall high c0–c1.
- Load half at 0x0000_0006, Gnt c2, RData=0x8001_1234 at c4 → MEM_ReadData=0xFFFF8001 with MEM_Done c5.
- Load byte at 0x0000_0001, RData=0x0000_7F00 → MEM_ReadData=0x0000007F; word load → 0x00007F00.
- Gnt never asserted, MAX_WAIT=15 → MEM_Done with MEM_BusError=1, MEM_ReadData=0, Mem_Req drops after 15 REQ cycles.
- Rst asserted in WAIT_R, RValid next cycle → IDLE, Mem_Req=0, no MEM_Done, LSU_Ready=1.
- With LSU_MISALIGN_TRAP_EN, word load at 0x0000_0002 → MEM_Done c1, MEM_Misaligned=1, Mem_Req never high; without macro → Mem_Addr=0, normal load.
